box_window_3x3: RTL
===================

# box_window_3x3

Streaming 3x3 window generator that sits directly upstream of `ternary_sum_nine`. It accepts one raster-order pixel per valid cycle and keeps two line buffers plus a 3x3 register window. For every pixel that completes a full in-image 3x3 neighbourhood, it presents nine registered taps `o_w0`..`o_w8`. Those taps wire straight to `i0`..`i8` of the nine-input adder to form a box-filter sum.

## Interface
- `WIDTH`, 32: pixel width in bits, equal to the downstream adder's `WIDTH`.
- `IMG_W`, 64: pixels per line. Legal range is 3 or more.
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `i_valid` input 1: the pixel on `i_pix` is accepted this cycle. There is no backpressure.
- `i_sof` input 1: start of frame, qualified by `i_valid`. The accepted pixel is row 0, column 0.
- `i_pix` input `WIDTH`: pixel data.
- `o_valid` output 1: `o_w0`..`o_w8` hold a complete window this cycle.
- `o_w0`..`o_w8` output `WIDTH` each: the window taps.
  - Rows: `o_w0`..`o_w2` are row r-2, `o_w3`..`o_w5` are row r-1, `o_w6`..`o_w8` are row r.
  - Within a row, the lowest index is column c-2 and the highest is column c.
- `o_sum_valid` output 1: present only with the configuration macro defined (see Configuration).

## Operation
- **Column counter.** Width is `$clog2(IMG_W)`.
  - Increments on each accepted pixel.
  - Wraps from `IMG_W-1` to 0.
- **Row counter.** 2 bits, saturating at 2.
  - Increments when the column counter wraps.
  - Reaching 2 means "row is 2 or later".
- **Start of frame.** On an accepted pixel with `i_sof`=1, that pixel is treated as column 0, row 0.
  - Both counters load the position following (0,0).
  - This happens regardless of their prior value, including mid-line or mid-frame.
- **Line buffers.** Two buffers, each one line deep and addressed by the current column.
  - Per accepted pixel, each buffer reads before it writes.
  - Line buffer A outputs pixel(r-1,c) and is written with `i_pix`.
  - Line buffer B outputs pixel(r-2,c) and is written with A's read data.
- **Window shift.** Per accepted pixel, each window row shifts left by one.
  - New entries: `o_w8`←`i_pix`, `o_w5`←A's read data, `o_w2`←B's read data.
  - Only accepted pixels move the window. It holds on `i_valid`=0.
- **Window-valid condition.** The accepted pixel is at row ≥2 and column ≥2, using pre-increment counter values.
  - Windows never straddle a line wrap.
  - There is no border padding. An H-row frame yields (H-2)·(`IMG_W`-2) windows.
- **Outputs.** Taps are only meaningful while `o_valid`=1.
  - The downstream adder consumes all nine taps unmasked.
  - Pixel values are passed through unmodified. There is no arithmetic in this block.
- **Reset.**
  - Counters and the window registers go to 0; `o_valid` and `o_sum_valid` go to 0.
  - Line-buffer contents are not reset; the row gating makes them don't-care.
  - Reset mid-frame discards the frame. The next window appears only after a fresh two-line fill, counted from the first pixel after reset, which is column 0, row 0.

## Timing
- **Latency.** One cycle from the accepted pixel that completes a window to `o_valid`=1.
  - `o_w8` then equals that pixel.
  - `o_w0` equals pixel(r-2,c-2).
- `o_valid` is registered and stays high for exactly one cycle per qualifying accepted pixel.
- Back-to-back `i_valid` sustains one window per cycle inside a row.
- Gaps in `i_valid` drop `o_valid` to 0. The taps hold their values during the gap.
- **Simultaneous events.** `i_sof` together with a column wrap: `i_sof` wins.
- A line-buffer read and write at the same address in the same cycle returns the old data (read-first).

## Configuration
- **`BOX_WINDOW_SUM_VALID_EN` defined:**
  - Adds output `o_sum_valid`, which is `o_valid` delayed through two registers, reset to 0.
  - It aligns with `o` of `ternary_sum_nine`, whose latency is two registered levels.
- **Undefined:** the port and its registers are absent. The downstream block carries its own valid tracking.

## Structure
- **Package `box_window_pkg`:**
  - Localparams `WIN_TAPS`=9 and `WIN_DIM`=3.
  - Row-counter width constant `ROW_CNT_W`=2.
  - A function returning the column counter width for a given `IMG_W`.
- **Sub-module `box_line_buffer`.** Instantiated twice.
  - Parameterized by `WIDTH` and `DEPTH`.
  - One-line read-first delay memory with ports `clk`, `we`, `addr`, `din`, `dout`.
  - Read data is available in the same cycle as the write. Inferable as distributed RAM or block RAM with output handling kept consistent with that behaviour.

## Test plan
- **Basic window.** `IMG_W`=4, 4x4 frame, `i_sof` on pixel 0, pixel value = raster index 0..15, continuous valid.
  - First `o_valid` comes one cycle after pixel 10, with taps 0,1,2,4,5,6,8,9,10.
  - The next window is 1,2,3,5,6,7,9,10,11. Exactly 4 windows in the frame.
- **Bubbles.** Same frame with `i_valid` deasserted every other cycle.
  - The identical 4 windows appear in the same order.
  - `o_valid` is never high on the cycle after a bubble.
- **Mid-frame restart.** `i_sof` reasserted on raster pixel 6.
  - No window appears until two full lines after the restart.
  - Restart pixel values 100..115 give a first window of 100,101,102,104,105,106,108,109,110.
- **Reset mid-frame.** `rst_n` pulsed low after pixel 12.
  - `o_valid` drops to 0 asynchronously and all taps read 0.
  - A post-reset frame behaves exactly as in the basic-window scenario.
- **Max values.** All pixels `{WIDTH{1'b1}}`.
  - Every tap equals all-ones.
  - The downstream sum reads 9·(2^`WIDTH`−1) with no truncation.
- **Macro.** `BOX_WINDOW_SUM_VALID_EN` defined.
  - `o_sum_valid` pulses exactly 2 cycles after each `o_valid` pulse.
  - `ternary_sum_nine.o` equals 45 on the first pulse of the basic-window frame.

Source files
------------

// File: rtl/box_window_pkg.sv
// Shared constants and types for the 3x3 box window generator.
package box_window_pkg;

    localparam int unsigned WIN_TAPS  = 9;
    localparam int unsigned WIN_DIM   = 3;
    localparam int unsigned ROW_CNT_W = 2;

    // ROW_FILLED means "row 2 or later": both line buffers hold lines of this frame.
    typedef enum logic [ROW_CNT_W-1:0] {
        ROW_0      = 2'd0,
        ROW_1      = 2'd1,
        ROW_FILLED = 2'd2
    } row_t;

    function automatic int unsigned col_cnt_w(input int unsigned img_w);
        return (img_w > 1) ? $clog2(img_w) : 1;
    endfunction

endpackage

// File: rtl/box_line_buffer.sv
// One-line read-first delay memory: dout shows the old word at addr while the write lands.
module box_line_buffer
    import box_window_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [col_cnt_w(DEPTH)-1:0]   addr,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/box_window_3x3.sv
// Streaming 3x3 window generator feeding a nine-input adder.
// Optional o_sum_valid port when BOX_WINDOW_SUM_VALID_EN is defined.
module box_window_3x3
    import box_window_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMG_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic [WIDTH-1:0] i_pix,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_w0,
    output logic [WIDTH-1:0] o_w1,
    output logic [WIDTH-1:0] o_w2,
    output logic [WIDTH-1:0] o_w3,
    output logic [WIDTH-1:0] o_w4,
    output logic [WIDTH-1:0] o_w5,
    output logic [WIDTH-1:0] o_w6,
    output logic [WIDTH-1:0] o_w7,
    output logic [WIDTH-1:0] o_w8
`ifdef BOX_WINDOW_SUM_VALID_EN
    ,
    output logic             o_sum_valid
`endif
);

    localparam int unsigned      COL_W    = col_cnt_w(IMG_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_nxt;
    logic [COL_W-1:0] pos_col;
    row_t             row_q;
    row_t             row_nxt;
    row_t             pos_row;
    logic             win_hit;

    logic [WIDTH-1:0] a_dout;
    logic [WIDTH-1:0] b_dout;
    logic [WIDTH-1:0] win [WIN_TAPS];

    // An SOF pixel is (0,0) regardless of the counters, so it also overrides a wrap.
    always_comb begin
        pos_col = i_sof ? '0 : col_q;
        pos_row = i_sof ? ROW_0 : row_q;
        col_nxt = col_q;
        row_nxt = row_q;
        win_hit = 1'b0;
        if (i_valid) begin
            win_hit = (pos_row == ROW_FILLED) && (pos_col >= COL_TWO);
            col_nxt = pos_col + COL_W'(1);
            row_nxt = pos_row;
            if (pos_col == COL_LAST) begin
                col_nxt = '0;
                case (pos_row)
                    ROW_0:   row_nxt = ROW_1;
                    default: row_nxt = ROW_FILLED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= ROW_0;
            o_valid <= 1'b0;
        end else begin
            col_q   <= col_nxt;
            row_q   <= row_nxt;
            o_valid <= win_hit;
        end
    end

    box_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line_a (
        .clk  (clk),
        .we   (i_valid),
        .addr (pos_col),
        .din  (i_pix),
        .dout (a_dout)
    );

    box_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line_b (
        .clk  (clk),
        .we   (i_valid),
        .addr (pos_col),
        .din  (a_dout),
        .dout (b_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIN_TAPS; i++) begin
                win[i] <= '0;
            end
        end else if (i_valid) begin
            for (int unsigned r = 0; r < WIN_DIM; r++) begin
                for (int unsigned c = 0; c < WIN_DIM - 1; c++) begin
                    win[r*WIN_DIM + c] <= win[r*WIN_DIM + c + 1];
                end
            end
            win[WIN_DIM-1]         <= b_dout;
            win[2*WIN_DIM-1]       <= a_dout;
            win[WIN_DIM*WIN_DIM-1] <= i_pix;
        end
    end

    assign o_w0 = win[0];
    assign o_w1 = win[1];
    assign o_w2 = win[2];
    assign o_w3 = win[3];
    assign o_w4 = win[4];
    assign o_w5 = win[5];
    assign o_w6 = win[6];
    assign o_w7 = win[7];
    assign o_w8 = win[8];

`ifdef BOX_WINDOW_SUM_VALID_EN
    logic [1:0] sum_valid_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid_pipe <= '0;
        end else begin
            sum_valid_pipe <= {sum_valid_pipe[0], o_valid};
        end
    end

    assign o_sum_valid = sum_valid_pipe[1];
`endif

endmodule
